// File: rtl/perceptron_trainer_if.sv
// perceptron_trainer_if: sample handshake and learned-weight export bus of the perceptron trainer.
interface perceptron_trainer_if #(parameter int WW = 8);
    logic in_valid, in_ready, target, res_valid, y_pred, mistake, converged;
    logic [3:0] x0, x1;
    logic signed [WW-1:0] w0, w1, bias;
    logic [7:0] err_cnt;
    modport master (
        output in_valid, x0, x1, target,
        input in_ready, w0, w1, bias, res_valid, y_pred, mistake, err_cnt, converged
    );
    modport slave (
        input in_valid, x0, x1, target,
        output in_ready, w0, w1, bias, res_valid, y_pred, mistake, err_cnt, converged
    );
endinterface

// File: rtl/perceptron_trainer.sv
// perceptron_trainer: online 2-input perceptron-rule trainer (IDLE/EVAL/UPDATE per sample).
// Define PERCEPTRON_TRAINER_SAT_EN to clamp weight updates instead of wrapping them.
module perceptron_trainer #(
    parameter int WW = 8,
    parameter int THRESH = 0,
    parameter logic signed [WW-1:0] W0_INIT = '0,
    parameter logic signed [WW-1:0] W1_INIT = '0,
    parameter logic signed [WW-1:0] BIAS_INIT = '0,
    parameter int CONV_RUN = 8
) (
    input logic clk,
    input logic rst_n,
    input logic clear,
    perceptron_trainer_if.slave bus
);
    localparam int SW = WW + 6;
    localparam int EW = WW + 5;
    localparam logic signed [SW-1:0] TH = SW'(THRESH);
    localparam logic [7:0] CR = 8'(CONV_RUN);
`ifdef PERCEPTRON_TRAINER_SAT_EN
    localparam logic signed [WW-1:0] WMAX = {1'b0, {(WW-1){1'b1}}};
    localparam logic signed [WW-1:0] WMIN = {1'b1, {(WW-1){1'b0}}};
`endif
    typedef enum logic [1:0] {IDLE, EVAL, UPDATE} state_t;
    state_t state, state_nx;
    logic [3:0] xl0, xl1;
    logic tl, y_q, mistake_q, res_q, y, up, dn;
    logic signed [WW-1:0] w0_q, w1_q, bias_q;
    logic [7:0] err_q, run_q;
    logic signed [SW-1:0] sum;
    // Products stay exact: zero-extended x is at most 15, so WW+6 bits cannot overflow.
    assign sum = SW'(w0_q) * SW'($signed({1'b0, xl0}))
               + SW'(w1_q) * SW'($signed({1'b0, xl1}))
               + SW'(bias_q);
    assign y = sum > TH;
    assign up = mistake_q & tl;
    assign dn = mistake_q & ~tl;
    function automatic logic signed [WW-1:0] step(input logic signed [WW-1:0] w, input logic [3:0] x);
        logic signed [EW-1:0] d, s;
        d = EW'($signed({1'b0, x}));
        s = EW'(w) + (up ? d : dn ? -d : '0);
`ifdef PERCEPTRON_TRAINER_SAT_EN
        return s > EW'(WMAX) ? WMAX : s < EW'(WMIN) ? WMIN : s[WW-1:0];
`else
        return s[WW-1:0];
`endif
    endfunction
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        if (clear) state_nx = IDLE;
        else if (state == IDLE) state_nx = bus.in_valid ? EVAL : IDLE;
        else if (state == EVAL) state_nx = UPDATE;
        else state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            xl0 <= '0;
            xl1 <= '0;
            tl <= 1'b0;
            y_q <= 1'b0;
            mistake_q <= 1'b0;
            res_q <= 1'b0;
            w0_q <= W0_INIT;
            w1_q <= W1_INIT;
            bias_q <= BIAS_INIT;
            err_q <= '0;
            run_q <= '0;
        end else if (clear) begin
            res_q <= 1'b0;
            w0_q <= W0_INIT;
            w1_q <= W1_INIT;
            bias_q <= BIAS_INIT;
            err_q <= '0;
            run_q <= '0;
        end else begin
            res_q <= state == UPDATE;
            if (state == IDLE && bus.in_valid) begin
                xl0 <= bus.x0;
                xl1 <= bus.x1;
                tl <= bus.target;
            end
            if (state == EVAL) begin
                y_q <= y;
                mistake_q <= y != tl;
            end
            if (state == UPDATE) begin
                w0_q <= step(w0_q, xl0);
                w1_q <= step(w1_q, xl1);
                bias_q <= step(bias_q, 4'd1);
                err_q <= mistake_q && err_q != 8'hFF ? err_q + 8'd1 : err_q;
                run_q <= mistake_q ? '0 : run_q == CR ? CR : run_q + 8'd1;
            end
        end
    assign bus.in_ready = state == IDLE;
    assign bus.w0 = w0_q;
    assign bus.w1 = w1_q;
    assign bus.bias = bias_q;
    assign bus.res_valid = res_q;
    assign bus.y_pred = y_q;
    assign bus.mistake = mistake_q;
    assign bus.err_cnt = err_q;
    assign bus.converged = run_q == CR;
endmodule

// File: tb/tb_perceptron_trainer.sv
// tb_perceptron_trainer: directed vectors with hand-computed expectations for perceptron_trainer.
module tb_perceptron_trainer;
    logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
    int vectors = 0, errs = 0;
    always #5 clk = ~clk;
    perceptron_trainer_if #(.WW(8)) bus();
    perceptron_trainer_if #(.WW(8)) sbus();
    perceptron_trainer dut (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus));
    // High threshold forces y=0 on x0=15 so the +15 step pushes 126 past the top of the range.
    perceptron_trainer #(.THRESH(2000), .W0_INIT(8'sd126)) dut_s (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(sbus));
    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic t, input logic ey, input logic em);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.x0 = a;
        bus.x1 = b;
        bus.target = t;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.x0 = ~a;
        bus.x1 = ~b;
        bus.target = ~t;
        chk("in_ready_eval", bus.in_ready, 0);
        @(negedge clk);
        chk("y_pred", bus.y_pred, ey);
        chk("mistake", bus.mistake, em);
        chk("res_early", bus.res_valid, 0);
        @(negedge clk);
        chk("res_valid", bus.res_valid, 1);
        chk("in_ready_idle", bus.in_ready, 1);
        chk("y_hold", bus.y_pred, ey);
    endtask
    task automatic weights(input int a, input int b, input int c, input int e);
        chk("w0", bus.w0, a);
        chk("w1", bus.w1, b);
        chk("bias", bus.bias, c);
        chk("err_cnt", bus.err_cnt, e);
    endtask
    initial begin
        bus.in_valid = 1'b0; bus.x0 = '0; bus.x1 = '0; bus.target = 1'b0;
        sbus.in_valid = 1'b0; sbus.x0 = '0; sbus.x1 = '0; sbus.target = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_converged", bus.converged, 0);
        chk("rst_y_pred", bus.y_pred, 0);
        weights(0, 0, 0, 0);
        chk("rst_w0_s", sbus.w0, 126);
        send(3, 2, 1, 0, 1);
        weights(3, 2, 1, 1);
        send(3, 2, 1, 1, 0);
        weights(3, 2, 1, 1);
        send(0, 0, 0, 1, 1);
        weights(3, 2, 0, 2);
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) send(3, 2, 1, 1, 0);
            else send(0, 0, 0, 0, 0);
            chk($sformatf("converged_%0d", i), bus.converged, i == 7 ? 1 : 0);
        end
        send(3, 2, 1, 1, 0);
        chk("converged_sat", bus.converged, 1);
        send(0, 0, 1, 0, 1);
        chk("converged_drop", bus.converged, 0);
        weights(3, 2, 1, 3);
        @(negedge clk);
        sbus.in_valid = 1'b1; sbus.x0 = 4'd15; sbus.x1 = 4'd0; sbus.target = 1'b1;
        @(negedge clk);
        sbus.in_valid = 1'b0;
        @(negedge clk);
        chk("sat_mistake", sbus.mistake, 1);
        @(negedge clk);
        chk("sat_res_valid", sbus.res_valid, 1);
`ifdef PERCEPTRON_TRAINER_SAT_EN
        chk("sat_w0", sbus.w0, 127);
`else
        chk("wrap_w0", sbus.w0, -115);
`endif
        chk("sat_bias", sbus.bias, 1);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.x0 = 4'd5; bus.x1 = 4'd5; bus.target = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_in_ready", bus.in_ready, 1);
        chk("clr_res_valid", bus.res_valid, 0);
        chk("clr_converged", bus.converged, 0);
        weights(0, 0, 0, 0);
        chk("clr_w0_s", sbus.w0, 126);
        @(negedge clk);
        chk("clr_no_res", bus.res_valid, 0);
        @(negedge clk);
        chk("clr_no_res2", bus.res_valid, 0);
        send(3, 2, 1, 0, 1);
        weights(3, 2, 1, 1);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.x0 = 4'd1; bus.x1 = 4'd1; bus.target = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", bus.in_ready, 1);
        chk("arst_w0", bus.w0, 0);
        chk("arst_err_cnt", bus.err_cnt, 0);
        chk("arst_mistake", bus.mistake, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_res_valid", bus.res_valid, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
